lcd_msg_queue: RTL and testbench

LCD_MSG_QUEUE -- requirements
Module: lcd_msg_queue

---
 rtl/lcd_i2c_pkg.sv | 22 ++
 rtl/byte_fifo.sv | 53 +++++
 rtl/lcd_msg_queue.sv | 196 +++++++++++++++++++
 tb/tb_lcd_msg_queue.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_i2c_pkg.sv
// Shared types and byte constants for the LCD message queue: FSM states and
// the fixed I2C address / command bytes for the serial LCD backpack.
package lcd_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CMD,
        ST_CLR,
        ST_DATA,
        ST_GAP
    } state_t;

    localparam logic [7:0] ADDR_BYTE = 8'hE4;
    localparam logic [7:0] CMD       = 8'h7C;
    localparam logic [7:0] CLEAR     = 8'h2D;

    function automatic logic is_send_state(input state_t s);
        return (s == ST_ADDR) || (s == ST_CMD) || (s == ST_CLR) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// DEPTH x 8 circular byte store with push/pop and an occupancy count.
// The head byte is always visible so the sender can load it without a read cycle.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/lcd_msg_queue.sv
// Queues bytes for a serial LCD and sends them as one I2C write on commit:
// address byte, optional clear command pair, then the committed data bytes.
module lcd_msg_queue
    import lcd_i2c_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 2000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_valid,
    input  logic [7:0]             wr_data,
    output logic                   wr_ready,
    input  logic                   commit,
    input  logic                   clear_first,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   tx_first,
    output logic                   tx_last,
    input  logic                   tx_done,
    input  logic                   tx_nak,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] PEND_ONE   = CW'(1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] GAP_PENULT = GW'(GAP_CYCLES - 2);
    localparam logic          GAP_ONE    = (GAP_CYCLES == 1);

    state_t        state_reg;
    logic [CW-1:0] pend_reg;
    logic          clr_reg;
    logic          flush_reg;
    logic [GW-1:0] gap_cnt_reg;
    logic          tx_start_reg;
    logic [7:0]    tx_data_reg;
    logic          tx_first_reg;
    logic          tx_last_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          error_reg;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic [7:0]    load_data;
    logic          load_last;

    // No bypass: a full FIFO refuses writes even while a byte is being popped.
    assign wr_ready  = (fifo_count < DEPTH_C);
    assign fifo_push = wr_valid && wr_ready;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Byte presented when a send state (re)asserts tx_start; pend counts the
    // data bytes not yet acknowledged, including the one on the wire in DATA.
    always_comb begin
        load_data = ADDR_BYTE;
        load_last = 1'b0;
        fifo_pop  = 1'b0;
        case (state_reg)
            ST_CMD: begin
                load_data = CMD;
            end
            ST_CLR: begin
                load_data = CLEAR;
                load_last = (pend_reg == '0);
            end
            ST_DATA: begin
                load_data = fifo_head;
                load_last = (pend_reg == PEND_ONE);
                if (flush_reg) begin
                    fifo_pop = (pend_reg != '0);
                end else begin
                    fifo_pop = tx_start_reg && tx_done && !tx_nak;
                end
            end
            default: begin
                load_data = ADDR_BYTE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            pend_reg     <= '0;
            clr_reg      <= 1'b0;
            flush_reg    <= 1'b0;
            gap_cnt_reg  <= '0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= '0;
            tx_first_reg <= 1'b0;
            tx_last_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (commit && ((fifo_count != '0) || clear_first)) begin
                    pend_reg     <= fifo_count;
                    clr_reg      <= clear_first;
                    error_reg    <= 1'b0;
                    busy_reg     <= 1'b1;
                    state_reg    <= ST_ADDR;
                    tx_start_reg <= 1'b1;
                    tx_data_reg  <= ADDR_BYTE;
                    tx_first_reg <= 1'b1;
                    tx_last_reg  <= 1'b0;
                end
            end else if (is_send_state(state_reg)) begin
                if (flush_reg) begin
                    // Discard the rest of a NAKed message, one byte per clock.
                    pend_reg <= pend_reg - 1'b1;
                    if (pend_reg == PEND_ONE) begin
                        flush_reg   <= 1'b0;
                        state_reg   <= ST_GAP;
                        gap_cnt_reg <= '0;
                        done_reg    <= GAP_ONE;
                    end
                end else if (!tx_start_reg) begin
                    tx_start_reg <= 1'b1;
                    tx_first_reg <= 1'b0;
                    tx_data_reg  <= load_data;
                    tx_last_reg  <= load_last;
                end else if (tx_done) begin
                    tx_start_reg <= 1'b0;
                    tx_first_reg <= 1'b0;
                    tx_last_reg  <= 1'b0;
                    if (tx_nak) begin
                        error_reg <= 1'b1;
                        if (pend_reg != '0) begin
                            flush_reg <= 1'b1;
                            state_reg <= ST_DATA;
                        end else begin
                            state_reg   <= ST_GAP;
                            gap_cnt_reg <= '0;
                            done_reg    <= GAP_ONE;
                        end
                    end else if (state_reg == ST_ADDR) begin
                        state_reg <= clr_reg ? ST_CMD : ST_DATA;
                    end else if (state_reg == ST_CMD) begin
                        state_reg <= ST_CLR;
                    end else if ((state_reg == ST_CLR) && (pend_reg != '0)) begin
                        state_reg <= ST_DATA;
                    end else if ((state_reg == ST_DATA) && (pend_reg != PEND_ONE)) begin
                        pend_reg <= pend_reg - 1'b1;
                    end else begin
                        pend_reg    <= '0;
                        state_reg   <= ST_GAP;
                        gap_cnt_reg <= '0;
                        done_reg    <= GAP_ONE;
                    end
                end
            end else begin
                // ST_GAP: done is raised so that it is high on the final gap cycle.
                if (gap_cnt_reg == GAP_LAST) begin
                    state_reg   <= ST_IDLE;
                    busy_reg    <= 1'b0;
                    gap_cnt_reg <= '0;
                end else begin
                    gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    done_reg    <= (gap_cnt_reg == GAP_PENULT);
                end
            end
        end
    end

    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;
    assign tx_first = tx_first_reg;
    assign tx_last  = tx_last_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign error    = error_reg;
    assign count    = fifo_count;

endmodule

// File: tb/tb_lcd_msg_queue.sv
// Directed and randomized bench for lcd_msg_queue with a behavioural byte
// engine and a queue-based model of what each committed message should send.
module tb_lcd_msg_queue;

    localparam int DEPTH = 16;
    localparam int GAP   = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic          commit;
    logic          clear_first;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_first;
    logic          tx_last;
    logic          tx_done;
    logic          tx_nak;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] count;

    lcd_msg_queue #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .commit      (commit),
        .clear_first (clear_first),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_first    (tx_first),
        .tx_last     (tx_last),
        .tx_done     (tx_done),
        .tx_nak      (tx_nak),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .count       (count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] model_q[$];
    logic [9:0] cap_q[$];
    logic [9:0] exp_q[$];
    int         ack_dly      = 0;
    int         nak_at       = -1;
    int         eng_wait     = -1;
    int         eng_done_cyc = 0;
    logic [7:0] eng_cur      = '0;
    int         cur_pend     = 0;
    bit         cur_accept   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Byte engine: acks each byte ack_dly cycles after it appears (random if 0).
    initial begin
        tx_done = 1'b0;
        tx_nak  = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            tx_done = 1'b0;
            tx_nak  = 1'b0;
            if (reset) begin
                eng_wait = -1;
            end else if (eng_wait < 0) begin
                if (tx_start) begin
                    if (cap_q.size() > 0) chk("start_gap", cyc - eng_done_cyc, 2);
                    cap_q.push_back({tx_first, tx_last, tx_data});
                    eng_cur  = tx_data;
                    eng_wait = (ack_dly > 0) ? ack_dly : int'($urandom_range(1, 5));
                end
            end else begin
                chk("tx_hold", {23'd0, tx_start, tx_data}, {23'd0, 1'b1, eng_cur});
                eng_wait--;
                if (eng_wait == 0) begin
                    tx_done      = 1'b1;
                    tx_nak       = ((cap_q.size() - 1) == nak_at);
                    eng_done_cyc = cyc;
                    eng_wait     = -1;
                end
            end
        end
    end

    task automatic write_byte(input logic [7:0] b, input bit check_ready);
        wr_valid = 1'b1;
        wr_data  = b;
        if (check_ready) chk("wr_ready", wr_ready, model_q.size() < DEPTH);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic start_txn(input bit clr, input int nak_i, input int dly);
        int total;
        cap_q.delete();
        exp_q.delete();
        nak_at     = nak_i;
        ack_dly    = dly;
        cur_pend   = model_q.size();
        cur_accept = (cur_pend > 0) || clr;
        total      = 1 + (clr ? 2 : 0) + cur_pend;
        if (cur_accept) begin
            for (int i = 0; i < total; i++) begin
                logic [7:0] b;
                if (i == 0) b = 8'hE4;
                else if (clr && i == 1) b = 8'h7C;
                else if (clr && i == 2) b = 8'h2D;
                else b = model_q[i - 1 - (clr ? 2 : 0)];
                exp_q.push_back({i == 0, i == total - 1, b});
            end
        end
        commit      = 1'b1;
        clear_first = clr;
        step();
        commit      = 1'b0;
        clear_first = 1'b0;
        chk("busy_accept", busy, cur_accept);
        if (cur_accept) chk("error_cleared", error, 1'b0);
    endtask

    task automatic finish_txn();
        bit got;
        int n_exp;
        bit naked;
        got = 0;
        if (!cur_accept) begin
            repeat (4) step();
            chk("no_busy", busy, 1'b0);
            chk("no_bytes", cap_q.size(), 0);
            return;
        end
        for (int k = 0; k < 3000 && !got; k++) begin
            if (done) got = 1;
            else step();
        end
        chk("done_seen", got, 1'b1);
        naked = (nak_at >= 0) && (nak_at < exp_q.size());
        if (!naked) chk("done_latency", cyc - eng_done_cyc, GAP);
        repeat (cur_pend) void'(model_q.pop_front());
        chk("count_after", count, model_q.size());
        chk("error_flag", error, naked);
        n_exp = naked ? nak_at + 1 : exp_q.size();
        chk("n_bytes", cap_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < cap_q.size(); i++) begin
            chk($sformatf("byte%0d", i), cap_q[i], exp_q[i]);
        end
        step();
        chk("done_pulse", done, 1'b0);
        chk("idle_after", busy, 1'b0);
    endtask

    initial begin
        logic [7:0] hello [5];
        int         n;
        bit         clr;
        int         len;
        int         nk;
        bit         reached;

        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        reset       = 1'b1;
        wr_valid    = 1'b0;
        wr_data     = '0;
        commit      = 1'b0;
        clear_first = 1'b0;
        step();
        step();
        chk("rst_count", count, 0);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_tx", {tx_start, tx_first, tx_last, tx_data}, 11'd0);
        chk("rst_flags", {busy, done, error}, 3'd0);
        #2 reset = 1'b0;
        step();

        // "HELLO", plain message, slow engine
        for (int i = 0; i < 5; i++) write_byte(hello[i], 1'b1);
        chk("hello_count", count, 5);
        start_txn(1'b0, -1, 20);
        finish_txn();

        // clear only, then an empty commit that must be ignored
        start_txn(1'b1, -1, 0);
        finish_txn();
        start_txn(1'b0, -1, 0);
        finish_txn();

        // fill to full, overflow write dropped, drain across pointer wrap
        for (int i = 0; i < DEPTH + 1; i++) write_byte(8'($urandom), 1'b1);
        chk("full_count", count, DEPTH);
        chk("full_ready", wr_ready, 1'b0);
        start_txn(1'b0, -1, 0);
        finish_txn();

        // bytes written mid-transaction stay queued
        for (int i = 0; i < 3; i++) write_byte(8'($urandom), 1'b1);
        start_txn(1'b0, -1, 0);
        write_byte(8'hA1, 1'b0);
        write_byte(8'hA2, 1'b0);
        finish_txn();

        // NAK on the second of four data bytes, then a commit clears error
        write_byte(8'hB1, 1'b1);
        write_byte(8'hB2, 1'b1);
        start_txn(1'b0, 2, 0);
        finish_txn();
        write_byte(8'hC1, 1'b1);
        start_txn(1'b1, -1, 0);
        finish_txn();

        // randomized messages
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(0, DEPTH);
            for (int i = 0; i < n; i++) write_byte(8'($urandom), 1'b1);
            clr = 1'($urandom_range(0, 1));
            len = 1 + (clr ? 2 : 0) + model_q.size();
            nk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            start_txn(clr, nk, 0);
            finish_txn();
        end

        // reset in the middle of the data phase
        for (int i = 0; i < 6; i++) write_byte(8'($urandom), 1'b1);
        start_txn(1'b0, -1, 4);
        reached = 0;
        for (int k = 0; k < 500 && !reached; k++) begin
            if (cap_q.size() >= 3) reached = 1;
            else step();
        end
        chk("reached_data", reached, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_tx", {tx_start, tx_first, tx_last, tx_data}, 11'd0);
        chk("mid_rst_flags", {busy, done, error}, 3'd0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ready", wr_ready, 1'b1);
        @(posedge clock);
        #2 reset = 1'b0;
        model_q.delete();
        cap_q.delete();
        step();
        step();
        chk("post_rst_count", count, 0);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_done", done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
